// File: rtl/pipe_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_hazard_ctrl
//
// Purpose
//   Hazard and stall controller for a five-stage in-order pipeline. It combines
//   three sources of pipeline disturbance into one set of pipeline-register
//   controls:
//     * data-memory wait states (the MEM stage holds until dmemReady),
//     * taken branches or jumps resolved in EX (the two younger stages are
//       squashed),
//     * load-use dependencies (ID is held for one cycle and a bubble is
//       inserted into ID/EX).
//   A small FSM (RUN / MEMWAIT / ERROR) tracks outstanding data-memory
//   accesses. If an access does not complete within TIMEOUT MEMWAIT cycles,
//   the block locks into ERROR, freezing the pipeline and raising a sticky
//   memErr until RESET.
//
// Parameters
//   TIMEOUT      maximum number of MEMWAIT cycles before ERROR (legal 2..255)
//
// Ports
//   CLOCK          in   1   clock, rising edge
//   RESET          in   1   asynchronous, active-low reset
//   idRs1, idRs2   in   5   source registers of the instruction in ID
//   idUseRs1/2     in   1   the ID instruction really reads rs1 / rs2
//   exMemRead      in   1   the ID/EX instruction is a load
//   exRd           in   5   destination register of the ID/EX instruction
//   exBranchTaken  in   1   branch / jump resolved taken in EX
//   memReq         in   1   EX/MEM instruction accesses data memory
//   dmemReady      in   1   data memory completes the access this cycle
//   pcEn, ifidEn,
//   idexEn, exmemEn out 1   load enables of PC and front pipeline registers
//   ifidFlush,
//   idexFlush      out  1   load a bubble into IF/ID / ID/EX
//   memwbBubble    out  1   load a bubble into MEM/WB
//   dmemStrobe     out  1   data-memory access request
//   memErr         out  1   sticky data-memory timeout error
//   stallCnt       out 16   stall-cycle counter (only with the macro below)
//
// Configuration
//   PIPE_HAZARD_STALL_STATS_EN  when defined, adds the 16-bit saturating
//                               stallCnt output counting load-use and
//                               mem-stall cycles.
//
// All outputs are combinational from the registered state and the current
// inputs; they are additionally forced low while RESET is asserted so the
// pipeline is fully quiescent during reset.
// -----------------------------------------------------------------------------
module pipe_hazard_ctrl #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        CLOCK,
    input  logic        RESET,
    input  logic [4:0]  idRs1,
    input  logic [4:0]  idRs2,
    input  logic        idUseRs1,
    input  logic        idUseRs2,
    input  logic        exMemRead,
    input  logic [4:0]  exRd,
    input  logic        exBranchTaken,
    input  logic        memReq,
    input  logic        dmemReady,
    output logic        pcEn,
    output logic        ifidEn,
    output logic        idexEn,
    output logic        exmemEn,
    output logic        ifidFlush,
    output logic        idexFlush,
    output logic        memwbBubble,
    output logic        dmemStrobe,
    output logic        memErr
`ifdef PIPE_HAZARD_STALL_STATS_EN
    ,
    output logic [15:0] stallCnt
`endif
);

    // -------------------------------------------------------------------------
    // State encoding
    // -------------------------------------------------------------------------
    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_MEMWAIT = 2'd1,
        ST_ERROR   = 2'd2
    } state_t;

    // waitCnt value seen in the last MEMWAIT cycle allowed before ERROR.
    // waitCnt is 0 in the first MEMWAIT cycle, so reaching TIMEOUT-1 means
    // TIMEOUT MEMWAIT cycles have elapsed.
    localparam logic [7:0] LP_WAIT_LAST = 8'(TIMEOUT - 1);

    state_t      r_state;
    state_t      w_next_state;
    logic [7:0]  r_wait_cnt;
    logic [7:0]  w_wait_cnt_next;

    // -------------------------------------------------------------------------
    // Load-use detection: one comparator per source operand.
    // -------------------------------------------------------------------------
    logic [4:0]  w_src_reg [2];
    logic [1:0]  w_src_use;
    logic [1:0]  w_src_hit;
    logic        w_load_use;

    assign w_src_reg[0] = idRs1;
    assign w_src_reg[1] = idRs2;
    assign w_src_use    = {idUseRs2, idUseRs1};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_src_cmp
            assign w_src_hit[gi] = w_src_use[gi] && (w_src_reg[gi] == exRd);
        end
    endgenerate

    // x0 is hard-wired to zero, so a load targeting it never creates a
    // dependency even if an operand names x0.
    assign w_load_use = exMemRead && (exRd != 5'd0) && (|w_src_hit);

    // -------------------------------------------------------------------------
    // Condition decode (priority: ERROR > mem-stall > branch > load-use)
    // -------------------------------------------------------------------------
    logic w_in_run;
    logic w_in_memwait;
    logic w_in_error;
    logic w_mem_stall;
    logic w_branch;
    logic w_lu_stall;

    assign w_in_run     = (r_state == ST_RUN);
    assign w_in_memwait = (r_state == ST_MEMWAIT);
    assign w_in_error   = (r_state == ST_ERROR);

    assign w_mem_stall  = (w_in_run && memReq && !dmemReady) ||
                          (w_in_memwait && !dmemReady);

    // A branch held in EX during a mem-stall is not lost: ID/EX is frozen, so
    // the branch is still presented here in the release cycle and flushes then.
    assign w_branch     = !w_in_error && !w_mem_stall && exBranchTaken;
    assign w_lu_stall   = !w_in_error && !w_mem_stall && !exBranchTaken &&
                          w_load_use;

    // -------------------------------------------------------------------------
    // State and wait counter registers
    // -------------------------------------------------------------------------
    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            r_state    <= ST_RUN;
            r_wait_cnt <= 8'd0;
        end else begin
            r_state    <= w_next_state;
            r_wait_cnt <= w_wait_cnt_next;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state and wait-counter logic
    // -------------------------------------------------------------------------
    always_comb begin
        w_next_state    = r_state;
        w_wait_cnt_next = r_wait_cnt;

        case (r_state)
            ST_RUN: begin
                if (memReq && !dmemReady) begin
                    w_next_state    = ST_MEMWAIT;
                    w_wait_cnt_next = 8'd0;
                end
            end

            ST_MEMWAIT: begin
                // Counter saturates rather than wrapping.
                if (r_wait_cnt != 8'hFF) begin
                    w_wait_cnt_next = r_wait_cnt + 8'd1;
                end
                if (dmemReady) begin
                    w_next_state = ST_RUN;
                end else if (r_wait_cnt == LP_WAIT_LAST) begin
                    w_next_state = ST_ERROR;
                end
            end

            ST_ERROR: begin
                // Terminal until RESET.
                w_next_state = ST_ERROR;
            end

            default: begin
                w_next_state    = ST_RUN;
                w_wait_cnt_next = 8'd0;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Pipeline control outputs
    // -------------------------------------------------------------------------
    always_comb begin
        pcEn        = 1'b0;
        ifidEn      = 1'b0;
        idexEn      = 1'b0;
        exmemEn     = 1'b0;
        ifidFlush   = 1'b0;
        idexFlush   = 1'b0;
        memwbBubble = 1'b0;
        dmemStrobe  = 1'b0;
        memErr      = 1'b0;

        if (RESET) begin
            // Strobe depends only on state: in RUN the request follows memReq,
            // in MEMWAIT it is held until the memory answers.
            case (r_state)
                ST_RUN:     dmemStrobe = memReq;
                ST_MEMWAIT: dmemStrobe = 1'b1;
                default:    dmemStrobe = 1'b0;
            endcase

            if (w_in_error) begin
                memwbBubble = 1'b1;
                memErr      = 1'b1;
            end else if (w_mem_stall) begin
                // Whole front of the pipe frozen; MEM/WB receives bubbles so
                // the stalled access does not write back more than once.
                memwbBubble = 1'b1;
            end else if (w_branch) begin
                pcEn      = 1'b1;
                ifidEn    = 1'b1;
                idexEn    = 1'b1;
                exmemEn   = 1'b1;
                ifidFlush = 1'b1;
                idexFlush = 1'b1;
            end else if (w_lu_stall) begin
                // Hold PC and IF/ID, let the load advance, and put a bubble
                // into ID/EX behind it.
                idexEn    = 1'b1;
                exmemEn   = 1'b1;
                idexFlush = 1'b1;
            end else begin
                pcEn    = 1'b1;
                ifidEn  = 1'b1;
                idexEn  = 1'b1;
                exmemEn = 1'b1;
            end
        end
    end

`ifdef PIPE_HAZARD_STALL_STATS_EN
    // -------------------------------------------------------------------------
    // Stall statistics: one count per load-use or mem-stall cycle, saturating.
    // ERROR cycles are not counted.
    // -------------------------------------------------------------------------
    logic [15:0] r_stall_cnt;
    logic        w_stall_evt;

    assign w_stall_evt = w_mem_stall || w_lu_stall;

    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            r_stall_cnt <= 16'd0;
        end else if (w_stall_evt && (r_stall_cnt != 16'hFFFF)) begin
            r_stall_cnt <= r_stall_cnt + 16'd1;
        end
    end

    assign stallCnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pipe_hazard_ctrl
//
// Directed testbench for pipe_hazard_ctrl (TIMEOUT = 4). Inputs are driven
// 1 time unit after the rising edge; outputs are checked on the falling edge.
// The observed output vector is
//   {pcEn, ifidEn, idexEn, exmemEn, ifidFlush, idexFlush,
//    memwbBubble, dmemStrobe, memErr}
// Define PIPE_HAZARD_STALL_STATS_EN to also check stallCnt.
// -----------------------------------------------------------------------------
module tb_pipe_hazard_ctrl;

    logic        CLOCK = 1'b0;
    logic        RESET;
    logic [4:0]  idRs1;
    logic [4:0]  idRs2;
    logic        idUseRs1;
    logic        idUseRs2;
    logic        exMemRead;
    logic [4:0]  exRd;
    logic        exBranchTaken;
    logic        memReq;
    logic        dmemReady;
    logic        pcEn;
    logic        ifidEn;
    logic        idexEn;
    logic        exmemEn;
    logic        ifidFlush;
    logic        idexFlush;
    logic        memwbBubble;
    logic        dmemStrobe;
    logic        memErr;
`ifdef PIPE_HAZARD_STALL_STATS_EN
    logic [15:0] stallCnt;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    always #5 CLOCK = ~CLOCK;

    pipe_hazard_ctrl #(.TIMEOUT(4)) dut (
        .CLOCK         (CLOCK),
        .RESET         (RESET),
        .idRs1         (idRs1),
        .idRs2         (idRs2),
        .idUseRs1      (idUseRs1),
        .idUseRs2      (idUseRs2),
        .exMemRead     (exMemRead),
        .exRd          (exRd),
        .exBranchTaken (exBranchTaken),
        .memReq        (memReq),
        .dmemReady     (dmemReady),
        .pcEn          (pcEn),
        .ifidEn        (ifidEn),
        .idexEn        (idexEn),
        .exmemEn       (exmemEn),
        .ifidFlush     (ifidFlush),
        .idexFlush     (idexFlush),
        .memwbBubble   (memwbBubble),
        .dmemStrobe    (dmemStrobe),
        .memErr        (memErr)
`ifdef PIPE_HAZARD_STALL_STATS_EN
        ,
        .stallCnt      (stallCnt)
`endif
    );

    logic [15:0] w_obs;
    assign w_obs = {7'd0, pcEn, ifidEn, idexEn, exmemEn, ifidFlush, idexFlush,
                    memwbBubble, dmemStrobe, memErr};

    //                                  pi i e f f   b s e
    localparam logic [8:0] E_ZERO   = 9'b0000_00_000;
    localparam logic [8:0] E_RUN    = 9'b1111_00_000;
    localparam logic [8:0] E_STROBE = 9'b1111_00_010;
    localparam logic [8:0] E_LU     = 9'b0011_01_000;
    localparam logic [8:0] E_BR     = 9'b1111_11_000;
    localparam logic [8:0] E_STALL  = 9'b0000_00_110;
    localparam logic [8:0] E_REL_BR = 9'b1111_11_010;
    localparam logic [8:0] E_ERR    = 9'b0000_00_101;

    task automatic check(input string tag, input logic [15:0] obs,
                         input logic [15:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
        $display("[TB] %s: observed %b expected %b", tag, obs, exp);
    endtask

    // Check the current cycle's outputs on the falling edge, then advance to
    // just after the next rising edge.
    task automatic cyc(input string tag, input logic [8:0] e);
        @(negedge CLOCK);
        check(tag, w_obs, {7'd0, e});
        @(posedge CLOCK);
        #1;
    endtask

    task automatic clr_in();
        idRs1 = 5'd0; idRs2 = 5'd0; idUseRs1 = 1'b0; idUseRs2 = 1'b0;
        exMemRead = 1'b0; exRd = 5'd0; exBranchTaken = 1'b0;
        memReq = 1'b0; dmemReady = 1'b0;
    endtask

    initial begin
        // ---------------- reset ----------------
        RESET = 1'b0;
        clr_in();
        memReq = 1'b1;
        exBranchTaken = 1'b1;
        repeat (2) @(posedge CLOCK);
        @(negedge CLOCK);
        check("reset_outputs", w_obs, {7'd0, E_ZERO});
`ifdef PIPE_HAZARD_STALL_STATS_EN
        check("reset_stallcnt", stallCnt, 16'd0);
`endif
        @(posedge CLOCK);
        #1;
        RESET = 1'b1;
        clr_in();
        cyc("idle_run", E_RUN);

        // ---------------- load-use on rs1 ----------------
        exMemRead = 1'b1; exRd = 5'd5; idRs1 = 5'd5; idUseRs1 = 1'b1;
        cyc("lu_rs1_stall", E_LU);
        exMemRead = 1'b0;                     // bubble now in EX
        cyc("lu_rs1_release", E_RUN);

        // ---------------- load-use on rs2 ----------------
        clr_in();
        exMemRead = 1'b1; exRd = 5'd7; idRs2 = 5'd7; idUseRs2 = 1'b1;
        idRs1 = 5'd3; idUseRs1 = 1'b1;
        cyc("lu_rs2_stall", E_LU);
        idUseRs2 = 1'b0;                      // match but operand unused
        cyc("lu_rs2_unused", E_RUN);

        // ---------------- x0 never stalls ----------------
        clr_in();
        exMemRead = 1'b1; exRd = 5'd0; idRs1 = 5'd0; idUseRs1 = 1'b1;
        cyc("lu_x0_nostall", E_RUN);

        // ---------------- not a load ----------------
        clr_in();
        exRd = 5'd9; idRs1 = 5'd9; idUseRs1 = 1'b1;
        cyc("nonload_nostall", E_RUN);

        // ---------------- branch beats load-use ----------------
        exMemRead = 1'b1; exBranchTaken = 1'b1;
        cyc("branch_over_lu", E_BR);

        // ---------------- mem-stall, 3 cycles, branch held in EX ----------
        clr_in();
        memReq = 1'b1; dmemReady = 1'b0;
        cyc("mem_stall_1_run", E_STALL);
        exBranchTaken = 1'b1;
        cyc("mem_stall_2_wait", E_STALL);
        cyc("mem_stall_3_wait", E_STALL);
        dmemReady = 1'b1;
        cyc("mem_release_branch", E_REL_BR);
        clr_in();
        cyc("after_release_run", E_RUN);
`ifdef PIPE_HAZARD_STALL_STATS_EN
        check("stallcnt_5", stallCnt, 16'd5);
`endif

        // ---------------- zero-wait access ----------------
        memReq = 1'b1; dmemReady = 1'b1;
        cyc("zero_wait_access", E_STROBE);
        clr_in();
        cyc("zero_wait_no_memwait", E_RUN);

        // ---------------- timeout -> ERROR ----------------
        memReq = 1'b1; dmemReady = 1'b0;
        cyc("to_run_stall", E_STALL);
        cyc("to_wait_0", E_STALL);
        cyc("to_wait_1", E_STALL);
        cyc("to_wait_2", E_STALL);
        cyc("to_wait_3", E_STALL);
        memReq = 1'b0; dmemReady = 1'b1; exBranchTaken = 1'b1;
        cyc("error_state", E_ERR);
        cyc("error_sticky", E_ERR);
`ifdef PIPE_HAZARD_STALL_STATS_EN
        check("stallcnt_10", stallCnt, 16'd10);
`endif
        RESET = 1'b0;
        #1;
        check("error_async_reset", w_obs, {7'd0, E_ZERO});
        #2;
        RESET = 1'b1;
        clr_in();
        cyc("error_cleared_run", E_RUN);

        // ---------------- reset abandons MEMWAIT ----------------
        memReq = 1'b1; dmemReady = 1'b0;
        cyc("rw_run_stall", E_STALL);
        cyc("rw_memwait_stall", E_STALL);
        RESET = 1'b0;
        #1;
        check("memwait_async_reset", w_obs, {7'd0, E_ZERO});
        #2;
        RESET = 1'b1;
        clr_in();
        cyc("memwait_abandoned_run", E_RUN);
`ifdef PIPE_HAZARD_STALL_STATS_EN
        check("stallcnt_after_reset", stallCnt, 16'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
